// File: rtl/fp_normalize_pipe_pkg.sv
// Shared FP definitions: format codes, field-length macros, op codes, flag bit positions.
// The macros are global to the compilation unit, so this file is compiled first.
`ifndef FP_DEFS_SVH
`define FP_DEFS_SVH
`define FP16 0
`define FP32 1
`define FP64 2
`define ADD 1'b0
`define SUB 1'b1
`define GET_EXP_LEN(fmt)      ((fmt) == `FP64 ? 11 : ((fmt) == `FP16 ? 5 : 8))
`define GET_MANTISSA_LEN(fmt) ((fmt) == `FP64 ? 52 : ((fmt) == `FP16 ? 10 : 23))
`define GET_PROTECT_LEN(fmt)  3
`endif

package fp_normalize_pipe_pkg;
    localparam int FLAG_W         = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_ZERO      = 0;

    typedef logic [FLAG_W-1:0] flags_t;
endpackage

// File: rtl/fp_normalize_pipe_if.sv
// Valid/ready bundle between a mantissa adder (master) and the normaliser (slave).
interface fp_normalize_pipe_if #(
    parameter int data_format = `FP32
);
    localparam int E = `GET_EXP_LEN(data_format);
    localparam int W = `GET_MANTISSA_LEN(data_format) + `GET_PROTECT_LEN(data_format) + 1;

    logic         in_valid;
    logic         in_ready;
    logic [E-1:0] exp;
    logic [W:0]   cal_result;
    logic         effective_op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] mant;
    logic [E-1:0] standardizing_exp;
    logic [2:0]   flags;

    modport master (
        output in_valid, exp, cal_result, effective_op, out_ready,
        input  in_ready, out_valid, mant, standardizing_exp, flags
    );

    modport slave (
        input  in_valid, exp, cal_result, effective_op, out_ready,
        output in_ready, out_valid, mant, standardizing_exp, flags
    );
endinterface

// File: rtl/fp_normalize_pipe_lzc.sv
// Combinational leading-zero counter; an all-zero input reports WIDTH.
module fp_lzc #(
    parameter int WIDTH = 27
) (
    input  logic [WIDTH-1:0]         din,
    output logic [$clog2(WIDTH+1)-1:0] cnt
);
    localparam int CW = $clog2(WIDTH + 1);

    // Scanning upward lets the highest set bit win.
    always_comb begin
        cnt = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (din[i]) cnt = CW'(WIDTH - 1 - i);
        end
    end
endmodule

// File: rtl/fp_normalize_pipe.sv
// Two-stage FP mantissa/exponent normaliser: S1 registers inputs + LZC, S2 registers result.
// Latency 2 cycles; each stage loads when empty or draining, so out_ready low stalls back to in_ready.
module fp_normalize_pipe
    import fp_normalize_pipe_pkg::*;
#(
    parameter int data_format = `FP32,
    parameter int STICKY_EN   = 1
) (
    input  logic               clk,
    input  logic               rst,
    fp_normalize_pipe_if.slave bus
);
    localparam int E  = `GET_EXP_LEN(data_format);
    localparam int W  = `GET_MANTISSA_LEN(data_format) + `GET_PROTECT_LEN(data_format) + 1;
    localparam int LW = $clog2(W + 1);
    localparam int SW = ((E > LW) ? E : LW) + 1;

    logic          s1_valid;
    logic [E-1:0]  s1_exp;
    logic [W:0]    s1_cal;
    logic          s1_op;
    logic [LW-1:0] s1_lzc;
    logic          s1_moves;
    logic [LW-1:0] lzc;

    logic          s2_valid;
    logic [W-1:0]  s2_mant;
    logic [E-1:0]  s2_exp;
    flags_t        s2_flags;

    logic [W-1:0]  nxt_mant;
    logic [E-1:0]  nxt_exp;
    flags_t        nxt_flags;
    logic [E-1:0]  exp_inc;
    logic [SW-1:0] shift;

    assign s1_moves     = !s2_valid || bus.out_ready;
    assign bus.in_ready = !s1_valid || s1_moves;

    fp_lzc #(.WIDTH(W)) u_lzc (
        .din (bus.cal_result[W-1:0]),
        .cnt (lzc)
    );

    always_comb begin
        nxt_mant  = s1_cal[W-1:0];
        nxt_exp   = s1_exp;
        nxt_flags = '0;
        exp_inc   = s1_exp + E'(1);
        shift     = '0;
        if (s1_cal == '0) begin
            nxt_mant             = '0;
            nxt_exp              = '0;
            nxt_flags[FLAG_ZERO] = 1'b1;
        end else if (s1_cal[W]) begin
            nxt_exp = exp_inc;
            if (&exp_inc) begin
                nxt_mant                 = '0;
                nxt_flags[FLAG_OVERFLOW] = 1'b1;
            end else begin
                nxt_mant    = s1_cal[W:1];
                nxt_mant[0] = s1_cal[1] | ((STICKY_EN != 0) & s1_cal[0]);
            end
        end else if (s1_op == `SUB && !s1_cal[W-1] && s1_exp != '0) begin
            // Shift is capped at exp-1 so a result that cannot normalise lands as subnormal.
            if (SW'(s1_lzc) < SW'(s1_exp)) begin
                shift   = SW'(s1_lzc);
                nxt_exp = s1_exp - E'(s1_lzc);
            end else begin
                shift                     = SW'(s1_exp) - SW'(1);
                nxt_exp                   = '0;
                nxt_flags[FLAG_UNDERFLOW] = 1'b1;
            end
            nxt_mant = s1_cal[W-1:0] << shift;
        end else if (s1_op == `ADD && s1_exp == '0 && s1_cal[W-1]) begin
            nxt_exp = E'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_exp   <= '0;
            s1_cal   <= '0;
            s1_op    <= 1'b0;
            s1_lzc   <= '0;
            s2_valid <= 1'b0;
            s2_mant  <= '0;
            s2_exp   <= '0;
            s2_flags <= '0;
        end else begin
            if (bus.in_ready) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_exp <= bus.exp;
                    s1_cal <= bus.cal_result;
                    s1_op  <= bus.effective_op;
                    s1_lzc <= lzc;
                end
            end
            if (s1_moves) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_mant  <= nxt_mant;
                    s2_exp   <= nxt_exp;
                    s2_flags <= nxt_flags;
                end
            end
        end
    end

    assign bus.out_valid         = s2_valid;
    assign bus.mant              = s2_mant;
    assign bus.standardizing_exp = s2_exp;
    assign bus.flags             = s2_flags;
endmodule

// File: tb/tb_fp_normalize_pipe.sv
// Randomised bench for fp_normalize_pipe (FP32) against an iterative normalisation model.
module tb_fp_normalize_pipe;
    import fp_normalize_pipe_pkg::*;

    localparam int   E      = 8;
    localparam int   W      = 27;
    localparam int   CW     = W + 1;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic [W-1:0] mant;
        logic [E-1:0] exp;
        flags_t       flags;
    } res_t;

    typedef struct packed {
        logic [E-1:0] exp;
        logic [W:0]   cal;
        logic         op;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run = 0;
    int   failed    = 0;

    fp_normalize_pipe_if bus ();
    fp_normalize_pipe dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Reference: shift one place at a time while the exponent can pay for it.
    function automatic res_t model(input beat_t b);
        res_t         r;
        int           e;
        logic [W-1:0] m;
        e       = int'(b.exp);
        m       = b.cal[W-1:0];
        r.flags = 3'b000;
        if (b.cal == '0) begin
            m = '0; e = 0; r.flags = 3'b001;
        end else if (b.cal[W]) begin
            e = int'(b.exp) + 1;
            if (e == 255) begin
                m = '0; r.flags = 3'b100;
            end else begin
                m = b.cal[W:1] | W'(b.cal[0]);
            end
        end else if (b.op == OP_SUB && b.exp != 0 && !b.cal[W-1]) begin
            while (!m[W-1] && e > 1) begin
                m = m << 1;
                e = e - 1;
            end
            if (!m[W-1]) begin
                e = 0; r.flags = 3'b010;
            end
        end else if (b.op == OP_ADD && b.exp == 0 && b.cal[W-1]) begin
            e = 1;
        end
        r.mant = m;
        r.exp  = e[E-1:0];
        return r;
    endfunction

    function automatic beat_t rand_beat();
        beat_t b;
        int    k;
        b.op  = 1'($urandom_range(0, 1));
        b.exp = E'($urandom_range(0, 254));
        b.cal = CW'({$urandom, $urandom});
        case ($urandom_range(0, 5))
            0: b.cal = '0;
            1: begin
                b.cal[W] = 1'b1;
                if ($urandom_range(0, 3) == 0) b.exp = 8'hFE;
            end
            2: begin
                k = $urandom_range(0, W - 1);
                b.cal = b.cal & ((CW'(1) << k) - CW'(1));
                b.cal[k] = 1'b1;
                b.op = OP_SUB;
                if ($urandom_range(0, 1) == 1) b.exp = E'($urandom_range(1, 30));
            end
            3: begin
                b.op = OP_ADD; b.exp = '0; b.cal[W] = 1'b0; b.cal[W-1] = 1'b1;
            end
            default: ;
        endcase
        return b;
    endfunction

    task automatic drive(input beat_t b);
        bus.in_valid     = 1'b1;
        bus.exp          = b.exp;
        bus.cal_result   = b.cal;
        bus.effective_op = b.op;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.exp = '0; bus.cal_result = '0; bus.effective_op = OP_ADD;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++; if (bus.out_valid !== 1'b0) begin failed++; $display("FAIL reset out_valid: got %b expected 0", bus.out_valid); end
        tests_run++; if (bus.mant !== '0) begin failed++; $display("FAIL reset mant: got %h expected 0", bus.mant); end
        tests_run++; if (bus.standardizing_exp !== '0) begin failed++; $display("FAIL reset exp: got %h expected 0", bus.standardizing_exp); end
        tests_run++; if (bus.flags !== 3'b000) begin failed++; $display("FAIL reset flags: got %b expected 000", bus.flags); end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        tests_run++; if (bus.in_ready !== 1'b1) begin failed++; $display("FAIL reset in_ready: got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_directed();
        logic [E-1:0] v_exp [9];
        logic [W:0]   v_cal [9];
        logic         v_op  [9];
        logic [E-1:0] x_exp [9];
        logic [W-1:0] x_mant[9];
        logic [2:0]   x_flg [9];
        beat_t        b;
        v_exp  = '{8'h80, 8'h80, 8'h03, 8'hFE, 8'h50, 8'h00, 8'h40, 8'h10, 8'h00};
        v_cal  = '{28'h8000001, 28'h0100000, 28'h0000100, 28'h8000000, 28'h0000000,
                   28'h4000000, 28'h2000000, 28'h5000000, 28'h0000010};
        v_op   = '{OP_ADD, OP_SUB, OP_SUB, OP_ADD, OP_SUB, OP_ADD, OP_ADD, OP_SUB, OP_SUB};
        x_exp  = '{8'h81, 8'h7A, 8'h00, 8'hFF, 8'h00, 8'h01, 8'h40, 8'h10, 8'h00};
        x_mant = '{27'h4000001, 27'h4000000, 27'h0000400, 27'h0, 27'h0,
                   27'h4000000, 27'h2000000, 27'h5000000, 27'h0000010};
        x_flg  = '{3'b000, 3'b000, 3'b010, 3'b100, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000};
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            bus.out_ready = 1'b1;
            b.exp = v_exp[i]; b.cal = v_cal[i]; b.op = v_op[i];
            drive(b);
            @(posedge clk); #1 bus.in_valid = 1'b0;
            @(negedge clk);
            tests_run++; if (bus.out_valid !== 1'b0) begin failed++; $display("FAIL directed[%0d] early out_valid: got %b expected 0", i, bus.out_valid); end
            @(negedge clk);
            tests_run++; if (bus.out_valid !== 1'b1) begin failed++; $display("FAIL directed[%0d] out_valid: got %b expected 1", i, bus.out_valid); end
            tests_run++; if (bus.mant !== x_mant[i]) begin failed++; $display("FAIL directed[%0d] mant: got %h expected %h", i, bus.mant, x_mant[i]); end
            tests_run++; if (bus.standardizing_exp !== x_exp[i]) begin failed++; $display("FAIL directed[%0d] exp: got %h expected %h", i, bus.standardizing_exp, x_exp[i]); end
            tests_run++; if (bus.flags !== x_flg[i]) begin failed++; $display("FAIL directed[%0d] flags: got %b expected %b", i, bus.flags, x_flg[i]); end
        end
        @(posedge clk);
    endtask

    task automatic test_backpressure();
        beat_t b[5];
        res_t  x[5];
        res_t  cur, held;
        logic  have_held = 1'b0;
        int    sent = 0, recv = 0, drop_at = -1;
        for (int i = 0; i < 5; i++) begin
            b[i] = rand_beat();
            x[i] = model(b[i]);
        end
        for (int c = 0; c < 40 && recv < 5; c++) begin
            @(posedge clk); #1;
            bus.out_ready = (c >= 4);
            if (sent < 5) drive(b[sent]);
            else bus.in_valid = 1'b0;
            @(negedge clk);
            if (bus.in_valid && !bus.in_ready && drop_at < 0) drop_at = sent;
            if (bus.in_valid && bus.in_ready) sent++;
            if (bus.out_valid) begin
                cur = {bus.mant, bus.standardizing_exp, bus.flags};
                if (have_held) begin
                    tests_run++; if (cur !== held) begin failed++; $display("FAIL bp stable: got %h expected %h", cur, held); end
                end
                if (bus.out_ready) begin
                    if (recv < 5) begin
                        tests_run++; if (cur !== x[recv]) begin failed++; $display("FAIL bp beat%0d: got %h expected %h", recv, cur, x[recv]); end
                    end
                    recv++;
                    have_held = 1'b0;
                end else begin
                    held = cur; have_held = 1'b1;
                end
            end
        end
        bus.in_valid = 1'b0;
        tests_run++; if (drop_at !== 2) begin failed++; $display("FAIL bp in_ready drop: got after %0d beats expected 2", drop_at); end
        tests_run++; if (recv !== 5) begin failed++; $display("FAIL bp count: got %0d beats expected 5", recv); end
    endtask

    task automatic test_random();
        res_t  q[$];
        res_t  cur, held, want;
        beat_t cb;
        logic  pending = 1'b0, have_held = 1'b0;
        int    c = 0;
        bus.in_valid = 1'b0;
        while (c < 700 && !(c >= 600 && q.size() == 0)) begin
            @(posedge clk); #1;
            if (c < 600) begin
                bus.out_ready = ($urandom_range(0, 9) < 6);
                if (!pending) begin
                    if ($urandom_range(0, 9) < 7) begin
                        cb = rand_beat(); drive(cb); pending = 1'b1;
                    end else begin
                        bus.in_valid = 1'b0;
                    end
                end
            end else begin
                bus.out_ready = 1'b1; bus.in_valid = 1'b0; pending = 1'b0;
            end
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model(cb)); pending = 1'b0;
            end
            if (bus.out_valid) begin
                cur = {bus.mant, bus.standardizing_exp, bus.flags};
                if (have_held) begin
                    tests_run++; if (cur !== held) begin failed++; $display("FAIL rnd stable: got %h expected %h", cur, held); end
                end
                if (bus.out_ready) begin
                    have_held = 1'b0;
                    if (q.size() == 0) begin
                        tests_run++; failed++; $display("FAIL rnd spurious beat: got %h expected none", cur);
                    end else begin
                        want = q.pop_front();
                        tests_run++; if (cur !== want) begin failed++; $display("FAIL rnd beat: got %h expected %h", cur, want); end
                    end
                end else begin
                    held = cur; have_held = 1'b1;
                end
            end
            c++;
        end
        tests_run++; if (q.size() != 0) begin failed++; $display("FAIL rnd drain: got %0d beats left expected 0", q.size()); end
    endtask

    task automatic test_reset_midstream();
        beat_t a, b;
        int    seen = 0;
        a = rand_beat(); b = rand_beat();
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        drive(a);
        @(posedge clk); #1 drive(b);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tests_run++; if (bus.out_valid !== 1'b0) begin failed++; $display("FAIL midrst out_valid: got %b expected 0", bus.out_valid); end
        tests_run++; if (bus.mant !== '0) begin failed++; $display("FAIL midrst mant: got %h expected 0", bus.mant); end
        @(posedge clk); #1;
        rst = 1'b0; bus.out_ready = 1'b1;
        @(negedge clk);
        tests_run++; if (bus.in_ready !== 1'b1) begin failed++; $display("FAIL midrst in_ready: got %b expected 1", bus.in_ready); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        tests_run++; if (seen !== 0) begin failed++; $display("FAIL midrst ghost beats: got %0d expected 0", seen); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end
endmodule
